// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: word width, the NOP encoding and the IF/ID
// control-state encoding.
package cpu_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } if_id_state_t;

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode bus of the IF/ID register: fetch/hazard control in, the
// registered instruction, status and performance counters out.
interface if_id_reg_if;
   import cpu_pkg::*;

   logic              start_i;
   logic              hazard_i;
   logic              flush_i;
   logic [WORD_W-1:0] pc_i;
   logic [WORD_W-1:0] inst_i;
   logic [WORD_W-1:0] pc_o;
   logic [WORD_W-1:0] inst_o;
   logic              valid_o;
   logic              stall_err_o;
   logic [15:0]       stall_cnt_o;
   logic [15:0]       flush_cnt_o;

   modport master (
      output start_i, hazard_i, flush_i, pc_i, inst_i,
      input  pc_o, inst_o, valid_o, stall_err_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  start_i, hazard_i, flush_i, pc_i, inst_i,
      output pc_o, inst_o, valid_o, stall_err_o, stall_cnt_o, flush_cnt_o
   );

endinterface

// File: rtl/if_id_stall_wdog.sv
// Stall watchdog: tracks the current run of consecutive hazard holds and sets a
// sticky error once that run reaches STALL_MAX.
module if_id_stall_wdog
   import cpu_pkg::*;
#(
   parameter int unsigned STALL_MAX = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  if_id_state_t state,
   input  logic         start,
   input  logic         hazard,
   input  logic         flush,
   output logic         stall_err
);

   localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] run_len;
   logic [7:0] run_len_nxt;
   logic       hold;

   // A hold only happens while running, enabled, not flushing and hazarded.
   assign hold = ((state == S_RUN) || (state == S_STALL)) && start && !flush && hazard;

   always_comb begin
      run_len_nxt = 8'd0;
      if (hold) begin
         run_len_nxt = (state == S_RUN) ? 8'd1 : sat_inc(run_len);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         run_len   <= 8'd0;
         stall_err <= 1'b0;
      end else begin
         run_len <= run_len_nxt;
         if (hold && (run_len_nxt >= STALL_LIMIT)) begin
            stall_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with start/hazard gating, flush bubbles and a stall
// watchdog. Define IF_ID_PERF_CNT_EN to build the stall/flush event counters.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_INST  = cpu_pkg::NOP_INST,
   parameter int unsigned       STALL_MAX = 8
) (
   input logic         clk_i,
   input logic         rst_i,
   if_id_reg_if.slave  bus
);

   if_id_state_t      state;
   if_id_state_t      state_nxt;
   logic [WORD_W-1:0] pc_p1;
   logic [WORD_W-1:0] pc_nxt;
   logic [WORD_W-1:0] inst_p1;
   logic [WORD_W-1:0] inst_nxt;
   logic              vld_p1;
   logic              vld_nxt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_p1;
      inst_nxt  = inst_p1;
      vld_nxt   = vld_p1;
      case (state)
         S_IDLE: begin
            if (bus.start_i) begin
               state_nxt = S_RUN;
               pc_nxt    = bus.pc_i;
               inst_nxt  = bus.inst_i;
               vld_nxt   = 1'b1;
            end
         end
         S_RUN, S_STALL: begin
            // Flush beats hazard: a stalled instruction on the wrong path is discarded.
            if (!bus.start_i) begin
               state_nxt = S_IDLE;
               inst_nxt  = NOP_INST;
               vld_nxt   = 1'b0;
            end else if (bus.flush_i) begin
               state_nxt = S_RUN;
               pc_nxt    = bus.pc_i;
               inst_nxt  = NOP_INST;
               vld_nxt   = 1'b0;
            end else if (bus.hazard_i) begin
               state_nxt = S_STALL;
            end else begin
               state_nxt = S_RUN;
               pc_nxt    = bus.pc_i;
               inst_nxt  = bus.inst_i;
               vld_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---- stage p1: registered fetch output to ID ----
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_p1   <= '0;
         inst_p1 <= NOP_INST;
         vld_p1  <= 1'b0;
      end else begin
         pc_p1   <= pc_nxt;
         inst_p1 <= inst_nxt;
         vld_p1  <= vld_nxt;
      end
   end

   assign bus.pc_o    = pc_p1;
   assign bus.inst_o  = inst_p1;
   assign bus.valid_o = vld_p1;

   if_id_stall_wdog #(
      .STALL_MAX (STALL_MAX)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .state     (state),
      .start     (bus.start_i),
      .hazard    (bus.hazard_i),
      .flush     (bus.flush_i),
      .stall_err (bus.stall_err_o)
   );

`ifdef IF_ID_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   logic        active;

   assign active = (state == S_RUN) || (state == S_STALL);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt <= 16'h0;
         flush_cnt <= 16'h0;
      end else begin
         if (active && bus.hazard_i && !bus.flush_i) begin
            stall_cnt <= stall_cnt + 16'h1;
         end
         if (active && bus.flush_i && bus.start_i) begin
            flush_cnt <= flush_cnt + 16'h1;
         end
      end
   end

   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;
`else
   assign bus.stall_cnt_o = 16'h0;
   assign bus.flush_cnt_o = 16'h0;
`endif

endmodule
